// File: rtl/round_timer.sv
// round_timer: BCD countdown timer advanced by rising edges of an
// asynchronous slow tick. Counts down from a loaded two-digit BCD value,
// supports pause, and pulses expired once when the count reaches 00.
//
// Ports:
//   clk                   system clock, rising edge
//   reset                 asynchronous active-high reset
//   tick_in               slow square wave, asynchronous to clk
//   start                 single-cycle load/restart request
//   pause                 level; high freezes counting
//   init_tens, init_ones  BCD start value (digits >9 clamp to 9)
//   tens, ones            registered BCD remaining count
//   state                 encoded FSM state (IDLE/RUN/PAUSED/DONE)
//   running               registered, high only in RUN
//   expired               registered one-cycle pulse on reaching 00
module round_timer #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       start,
  input  logic       pause,
  input  logic [3:0] init_tens,
  input  logic [3:0] init_ones,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [1:0] state,
  output logic       running,
  output logic       expired
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] PAUSED = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [1:0]             r_state;
  logic [3:0]             r_tens;
  logic [3:0]             r_ones;
  logic                   r_running;
  logic                   r_expired;

  logic                   w_step;
  logic [3:0]             w_ld_tens;
  logic [3:0]             w_ld_ones;
  logic                   w_ld_zero;
  logic [1:0]             w_nxt_state;
  logic [3:0]             w_nxt_tens;
  logic [3:0]             w_nxt_ones;
  logic                   w_nxt_expired;

  // Synchronizer chain plus previous-sample flop for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], tick_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  // One-cycle step on each synchronized rising edge of tick_in.
  assign w_step = r_sync[SYNC_STAGES-1] & ~r_prev;

  // Load value with each digit clamped to a legal BCD digit.
  assign w_ld_tens = (init_tens > 4'd9) ? 4'd9 : init_tens;
  assign w_ld_ones = (init_ones > 4'd9) ? 4'd9 : init_ones;
  assign w_ld_zero = (w_ld_tens == 4'd0) && (w_ld_ones == 4'd0);

  // Next-state and next-count logic; start has priority in every state.
  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_tens    = r_tens;
    w_nxt_ones    = r_ones;
    w_nxt_expired = 1'b0;
    if (start) begin
      w_nxt_tens = w_ld_tens;
      w_nxt_ones = w_ld_ones;
      if (w_ld_zero) begin
        w_nxt_state   = DONE;
        // Back-to-back zero loads must not stretch the pulse.
        w_nxt_expired = ~r_expired;
      end else begin
        w_nxt_state = RUN;
      end
    end else begin
      case (r_state)
        RUN: begin
          if (pause) begin
            w_nxt_state = PAUSED;
          end else if (w_step) begin
            if ((r_tens == 4'd0) && (r_ones <= 4'd1)) begin
              w_nxt_tens    = 4'd0;
              w_nxt_ones    = 4'd0;
              w_nxt_state   = DONE;
              w_nxt_expired = 1'b1;
            end else if (r_ones == 4'd0) begin
              w_nxt_ones = 4'd9;
              w_nxt_tens = r_tens - 4'd1;
            end else begin
              w_nxt_ones = r_ones - 4'd1;
            end
          end
        end
        PAUSED: begin
          if (!pause) begin
            w_nxt_state = RUN;
          end
        end
        IDLE, DONE: begin
          w_nxt_state = r_state;
        end
        default: begin
          w_nxt_state = IDLE;
        end
      endcase
    end
  end

  // State, count and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_tens    <= 4'd0;
      r_ones    <= 4'd0;
      r_running <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_tens    <= w_nxt_tens;
      r_ones    <= w_nxt_ones;
      r_running <= (w_nxt_state == RUN);
      r_expired <= w_nxt_expired;
    end
  end

  assign tens    = r_tens;
  assign ones    = r_ones;
  assign state   = r_state;
  assign running = r_running;
  assign expired = r_expired;

endmodule

// File: tb/tb_round_timer.sv
// tb_round_timer: directed self-checking bench for round_timer.
// Observed vector obs = {state, tens, ones, running, expired}.
module tb_round_timer;

  localparam int unsigned S = 2;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] PAUSED = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_in = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [3:0] init_tens = 4'd0;
  logic [3:0] init_ones = 4'd0;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [1:0] state;
  logic       running;
  logic       expired;

  logic [11:0] obs;
  logic [11:0] exp_v;
  int checks = 0;
  int failures = 0;
  int exp_cycles = 0;
  int e0;

  round_timer #(.SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .tick_in(tick_in), .start(start),
    .pause(pause), .init_tens(init_tens), .init_ones(init_ones),
    .tens(tens), .ones(ones), .state(state), .running(running),
    .expired(expired)
  );

  always #5 clk = ~clk;

  assign obs = {state, tens, ones, running, expired};

  // Count cycles in which expired is high.
  always @(negedge clk) if (expired === 1'b1) exp_cycles++;

  task automatic do_start(input logic [3:0] t, input logic [3:0] o);
    @(negedge clk);
    init_tens = t; init_ones = o; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_tick();
    @(negedge clk) tick_in = 1'b1;
    repeat (S + 2) @(negedge clk);
    tick_in = 1'b0;
    repeat (S + 2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    exp_v = 12'h000; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL reset_state got=%h exp=%h", obs, exp_v); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_latency();
    logic [3:0] pt [3];
    logic [3:0] po [3];
    logic [3:0] nt [3];
    logic [3:0] no [3];
    pt = '{4'd3, 4'd3, 4'd3}; po = '{4'd2, 4'd1, 4'd0};
    nt = '{4'd3, 4'd3, 4'd2}; no = '{4'd1, 4'd0, 4'd9};
    do_start(4'd3, 4'd2);
    exp_v = {RUN, 4'd3, 4'd2, 2'b10}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL latency_load got=%h exp=%h", obs, exp_v); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) tick_in = 1'b1;
      repeat (S) @(posedge clk);
      #1;
      exp_v = {RUN, pt[i], po[i], 2'b10}; checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL latency_early%0d got=%h exp=%h", i, obs, exp_v); end
      @(posedge clk);
      #1;
      exp_v = {RUN, nt[i], no[i], 2'b10}; checks++;
      if (obs !== exp_v) begin failures++; $display("FAIL latency_step%0d got=%h exp=%h", i, obs, exp_v); end
      @(negedge clk) tick_in = 1'b0;
      repeat (S + 2) @(negedge clk);
    end
  endtask

  task automatic test_expire();
    do_start(4'd0, 4'd2);
    e0 = exp_cycles;
    pulse_tick();
    exp_v = {RUN, 4'd0, 4'd1, 2'b10}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL expire_01 got=%h exp=%h", obs, exp_v); end
    @(negedge clk) tick_in = 1'b1;
    repeat (S + 1) @(posedge clk);
    #1;
    exp_v = {DONE, 4'd0, 4'd0, 2'b01}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL expire_00 got=%h exp=%h", obs, exp_v); end
    @(posedge clk);
    #1;
    exp_v = {DONE, 4'd0, 4'd0, 2'b00}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL expire_drop got=%h exp=%h", obs, exp_v); end
    @(negedge clk) tick_in = 1'b0;
    repeat (S + 2) @(negedge clk);
    pulse_tick();
    pulse_tick();
    exp_v = {DONE, 4'd0, 4'd0, 2'b00}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL expire_hold got=%h exp=%h", obs, exp_v); end
    checks++;
    if (exp_cycles - e0 !== 1) begin failures++; $display("FAIL expire_pulses got=%0d exp=1", exp_cycles - e0); end
  endtask

  task automatic test_pause();
    do_start(4'd1, 4'd5);
    @(negedge clk) pause = 1'b1;
    @(negedge clk);
    exp_v = {PAUSED, 4'd1, 4'd5, 2'b00}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL pause_enter got=%h exp=%h", obs, exp_v); end
    repeat (3) pulse_tick();
    exp_v = {PAUSED, 4'd1, 4'd5, 2'b00}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL pause_hold got=%h exp=%h", obs, exp_v); end
    pause = 1'b0;
    @(negedge clk);
    exp_v = {RUN, 4'd1, 4'd5, 2'b10}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL pause_resume got=%h exp=%h", obs, exp_v); end
    pulse_tick();
    exp_v = {RUN, 4'd1, 4'd4, 2'b10}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL pause_step got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_clamp();
    do_start(4'hC, 4'hF);
    exp_v = {RUN, 4'd9, 4'd9, 2'b10}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL clamp_99 got=%h exp=%h", obs, exp_v); end
    e0 = exp_cycles;
    do_start(4'd0, 4'd0);
    exp_v = {DONE, 4'd0, 4'd0, 2'b01}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL load00_done got=%h exp=%h", obs, exp_v); end
    @(negedge clk);
    exp_v = {DONE, 4'd0, 4'd0, 2'b00}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL load00_drop got=%h exp=%h", obs, exp_v); end
    pulse_tick();
    checks++;
    if (exp_cycles - e0 !== 1) begin failures++; $display("FAIL load00_pulses got=%0d exp=1", exp_cycles - e0); end
  endtask

  task automatic test_coincident();
    do_start(4'd4, 4'd0);
    exp_v = {RUN, 4'd4, 4'd0, 2'b10}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL coin_load40 got=%h exp=%h", obs, exp_v); end
    // Align start with the cycle in which step is high.
    @(negedge clk) tick_in = 1'b1;
    repeat (S) @(negedge clk);
    init_tens = 4'd2; init_ones = 4'd0; start = 1'b1;
    @(negedge clk) start = 1'b0;
    exp_v = {RUN, 4'd2, 4'd0, 2'b10}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL coin_start got=%h exp=%h", obs, exp_v); end
    repeat (S + 2) @(negedge clk);
    tick_in = 1'b0;
    repeat (S + 2) @(negedge clk);
    exp_v = {RUN, 4'd2, 4'd0, 2'b10}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL coin_after got=%h exp=%h", obs, exp_v); end
    pulse_tick();
    exp_v = {RUN, 4'd1, 4'd9, 2'b10}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL coin_borrow got=%h exp=%h", obs, exp_v); end
    // Pause asserted in the step cycle.
    @(negedge clk) tick_in = 1'b1;
    repeat (S) @(negedge clk);
    pause = 1'b1;
    @(negedge clk);
    exp_v = {PAUSED, 4'd1, 4'd9, 2'b00}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL coin_pause got=%h exp=%h", obs, exp_v); end
    pause = 1'b0;
    @(negedge clk);
    tick_in = 1'b0;
    repeat (S + 2) @(negedge clk);
    exp_v = {RUN, 4'd1, 4'd9, 2'b10}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL coin_pause_after got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_reset_mid();
    do_start(4'd0, 4'd2);
    pulse_tick();
    exp_v = {RUN, 4'd0, 4'd1, 2'b10}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL rmid_01 got=%h exp=%h", obs, exp_v); end
    e0 = exp_cycles;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    exp_v = 12'h000; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL rmid_async got=%h exp=%h", obs, exp_v); end
    tick_in = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (S + 3) @(negedge clk);
    exp_v = {IDLE, 4'd0, 4'd0, 2'b00}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL rmid_release got=%h exp=%h", obs, exp_v); end
    tick_in = 1'b0;
    repeat (S + 2) @(negedge clk);
    pulse_tick();
    pulse_tick();
    exp_v = {IDLE, 4'd0, 4'd0, 2'b00}; checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL rmid_edges got=%h exp=%h", obs, exp_v); end
    checks++;
    if (exp_cycles - e0 !== 0) begin failures++; $display("FAIL rmid_pulses got=%0d exp=0", exp_cycles - e0); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_expire();
    test_pause();
    test_clamp();
    test_coincident();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/round_timer.md
ROUND_TIMER -- requirements
Module: round_timer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of flops synchronizing tick_in (legal 2..4).
REQ-002 SHALL have port clk, input, 1, system clock; all flops on rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port tick_in, input, 1, slow square wave from the 10-second divider; treated as asynchronous to clk.
REQ-005 SHALL have port start, input, 1, single-cycle load/restart request.
REQ-006 SHALL have port pause, input, 1, level; high freezes counting.
REQ-007 SHALL have ports init_tens and init_ones, input, 4 each, BCD start value.
REQ-008 SHALL have ports tens and ones, output, 4 each, registered BCD remaining count.
REQ-009 SHALL have port state, output, 2, encoded FSM state.
REQ-010 SHALL have port running, output, 1, high only in RUN.
REQ-011 SHALL have port expired, output, 1, registered one-cycle pulse on reaching 00.

Function
REQ-012 SHALL pass tick_in through a SYNC_STAGES-flop synchronizer, then a one-flop previous-sample register.
REQ-013 SHALL generate internal step, one cycle wide, when synchronized value is 1 and previous sample is 0; only rising edges of tick_in count.
REQ-014 SHALL register step effects so counter changes SYNC_STAGES+1 clk cycles after a tick_in rising edge.
REQ-015 SHALL implement states IDLE=2'd0, RUN=2'd1, PAUSED=2'd2, DONE=2'd3.
REQ-016 IDLE: ignore step and pause; start -> load digits, go RUN.
REQ-017 Load SHALL clamp each digit: value >9 loads as 9.
REQ-018 Load of 00 SHALL go directly to DONE and assert expired next cycle.
REQ-019 RUN: on step, ones>0 -> ones-1; ones==0 -> ones=9, tens-1.
REQ-020 RUN: step taking count 01 -> 00 SHALL go to DONE and pulse expired in the same cycle the count shows 00.
REQ-021 RUN: pause high -> PAUSED; a step in the same cycle SHALL be ignored.
REQ-022 PAUSED: ignore step; count held; pause low -> RUN next cycle.
REQ-023 RUN or PAUSED: start SHALL reload and enter RUN regardless of pause; a coincident step SHALL be ignored.
REQ-024 DONE: hold 00, ignore step and pause; start -> reload, go RUN (or DONE per REQ-018).
REQ-025 expired SHALL never be high two consecutive cycles.
REQ-026 Count SHALL never wrap below 00; tens/ones always valid BCD (0..9).

Reset
REQ-027 reset high SHALL asynchronously force state=IDLE, tens=0, ones=0, running=0, expired=0, synchronizer and previous-sample flops to 0.
REQ-028 Reset mid-count SHALL discard the count; no expired pulse results.
REQ-029 After reset release, a high tick_in SHALL produce at most one spurious step, which is ignored because state is IDLE.

Verification
REQ-030 Load 0x3/0x2, start, 3 tick_in rising edges -> tens/ones 2/9, state RUN, each change exactly SYNC_STAGES+1 cycles after its edge.
REQ-031 Load 0/2, start, 2 edges -> 00, state DONE, expired high exactly one cycle; further edges leave 00.
REQ-032 Running at 1/5, pause high across 3 edges -> stays 1/5, state PAUSED; pause low then 1 edge -> 1/4.
REQ-033 Load 0xC/0xF -> count 9/9; load 0/0 with start -> DONE plus one expired pulse.
REQ-034 start coincident with step at 4/0 after reload of 2/0 -> count 2/0, no decrement; pause+step same cycle -> no decrement.
REQ-035 Assert reset at 0/1 mid-RUN -> all outputs zero immediately, state IDLE, no expired pulse; edges afterward do not change count.
